// File: rtl/hazard_sb.sv
// Hazard unit for the dual-ISA 5-stage core. It keeps a shadow scoreboard of
// the destination tags in flight in E/M/W. From that state it drives forwarding,
// load-use stalls, redirect flushes and the data-memory wait freeze.
module hazard_sb #(
    parameter int REG_W    = 5,
    parameter int MEM_LAT  = 1,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdD,
    input  logic             RegWriteD,
    input  logic             LoadD,
    input  logic             MemAccessD,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic             RedirectE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
        logic             mem;
    } tag_t;

    tag_t             tag_e_q, tag_e_d;
    tag_t             tag_m_q, tag_m_d;
    tag_t             tag_w_q, tag_w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             freeze_s;
    logic             loaduse_s;

    function automatic logic tag_match(input logic [REG_W-1:0] s, input tag_t t);
        return t.wr && (s == t.rd) && !((ZERO_REG != 0) && (s == {REG_W{1'b0}}));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] s, input tag_t tm, input tag_t tw);
        if (tag_match(s, tm) && !tm.ld) begin
            return 2'b10;
        end else if (tag_match(s, tw)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // With single-cycle memory there is no wait, so the counter compare is elided.
    generate
        if (MEM_LAT > 1) begin : g_wait
            assign freeze_s = tag_m_q.mem && (cnt_q < CNT_W'(MEM_LAT - 1));
        end else begin : g_nowait
            assign freeze_s = 1'b0;
        end
    endgenerate

    assign loaduse_s = tag_e_q.ld && (tag_match(Rs1D, tag_e_q) || tag_match(Rs2D, tag_e_q));

    // Stall/flush priority: freeze, then redirect, then load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (freeze_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (RedirectE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (loaduse_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else begin
            FlushW = 1'b0;
        end
    end

    // Operand forwarding select; M wins over W.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, tag_m_q, tag_w_q);
        ForwardBE = fwd_sel(Rs2E, tag_m_q, tag_w_q);
    end

    // Next scoreboard state: a freeze holds E/M and drains a bubble into W.
    always_comb begin
        tag_e_d = tag_e_q;
        tag_m_d = tag_m_q;
        tag_w_d = tag_w_q;
        cnt_d   = cnt_q;
        if (freeze_s) begin
            tag_w_d = '0;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            tag_w_d = tag_m_q;
            tag_m_d = tag_e_q;
            cnt_d   = '0;
            if (FlushE) begin
                tag_e_d = '0;
            end else begin
                tag_e_d = '{rd: RdD, wr: RegWriteD, ld: LoadD, mem: MemAccessD};
            end
        end
    end

    // Scoreboard and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_e_q <= '0;
            tag_m_q <= '0;
            tag_w_q <= '0;
            cnt_q   <= '0;
        end else begin
            tag_e_q <= tag_e_d;
            tag_m_q <= tag_m_d;
            tag_w_q <= tag_w_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: four instances with different MEM_LAT/ZERO_REG
// share one stimulus stream; expected output words are queued and checked at negedge.
module tb_hazard_sb;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E;
    logic       RegWriteD, LoadD, MemAccessD, RedirectE;
    logic [10:0] act [4];

    always #5 clk = ~clk;

    // dut0: ML=1 ZR=1, dut1: ML=1 ZR=0, dut2: ML=3 ZR=1, dut3: ML=4 ZR=1
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int ML = (g == 2) ? 3 : ((g == 3) ? 4 : 1);
        localparam int ZR = (g == 1) ? 0 : 1;
        logic       sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fa, fb;
        hazard_sb #(.REG_W(5), .MEM_LAT(ML), .ZERO_REG(ZR)) u_dut (
            .clk(clk), .rst(rst),
            .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
            .RegWriteD(RegWriteD), .LoadD(LoadD), .MemAccessD(MemAccessD),
            .Rs1E(Rs1E), .Rs2E(Rs2E), .RedirectE(RedirectE),
            .StallF(sf), .StallD(sd), .StallE(se), .StallM(sm),
            .FlushD(fd), .FlushE(fe), .FlushW(fw),
            .ForwardAE(fa), .ForwardBE(fb)
        );
        assign act[g] = {sf, sd, se, sm, fd, fe, fw, fa, fb};
    end

    // Control field order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    localparam logic [6:0] C0  = 7'b0000000;
    localparam logic [6:0] CLU = 7'b1100010;
    localparam logic [6:0] CRD = 7'b0000110;
    localparam logic [6:0] CFZ = 7'b1111001;

    int          n_cmp = 0;
    int          n_err = 0;
    int          q_idx [$];
    logic [10:0] q_exp [$];
    string       q_name [$];

    function automatic logic [10:0] mk(input logic [6:0] c, input logic [1:0] a, input logic [1:0] b);
        return {c, a, b};
    endfunction

    task automatic expect_out(input int idx, input string nm, input logic [10:0] e);
        q_idx.push_back(idx);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic check_now(input int idx, input string nm, input logic [10:0] e);
        n_cmp++;
        if (act[idx] !== e) begin
            n_err++;
            $display("FAIL %s: dut%0d got %b expected %b", nm, idx, act[idx], e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r1d, input logic [4:0] r2d, input logic [4:0] rdd,
                         input logic wr, input logic ld, input logic mem,
                         input logic [4:0] r1e, input logic [4:0] r2e, input logic redir);
        Rs1D = r1d; Rs2D = r2d; RdD = rdd;
        RegWriteD = wr; LoadD = ld; MemAccessD = mem;
        Rs1E = r1e; Rs2E = r2e; RedirectE = redir;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: drain every expectation queued for this cycle.
    always @(negedge clk) begin
        int          idx;
        logic [10:0] e;
        string       nm;
        while (q_exp.size() > 0) begin
            idx = q_idx.pop_front();
            e   = q_exp.pop_front();
            nm  = q_name.pop_front();
            n_cmp++;
            if (act[idx] !== e) begin
                n_err++;
                $display("FAIL %s: dut%0d got %b expected %b", nm, idx, act[idx], e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_now(i, "reset.now", mk(C0, 2'b00, 2'b00));
        for (int i = 0; i < 4; i++) expect_out(i, "reset", mk(C0, 2'b00, 2'b00));
        tick();
        rst = 1'b0;

        // Forwarding from M then W, no stalls
        drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_out(0, "fwd.a", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0);
        expect_out(0, "fwd.b", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0);
        expect_out(0, "fwd.m", mk(C0, 2'b10, 2'b00)); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd7, 1'b0);
        expect_out(0, "fwd.w_m", mk(C0, 2'b01, 2'b10)); tick();

        // Load-use: one stall cycle, no forward from a load in M, then W forward
        do_reset();
        drive(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        expect_out(0, "lu.a", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd6, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_out(0, "lu.stall", mk(CLU, 2'b00, 2'b00)); tick();
        drive(5'd6, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 5'd6, 5'd0, 1'b0);
        expect_out(0, "lu.noldfwd", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd6, 5'd3, 1'b0);
        expect_out(0, "lu.wfwd", mk(C0, 2'b01, 2'b00)); tick();

        // Redirect beats load-use
        do_reset();
        drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        expect_out(0, "rd.a", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd9, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
        expect_out(0, "rd.redir", mk(CRD, 2'b00, 2'b00)); tick();
        drive(5'd9, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_out(0, "rd.after", mk(C0, 2'b00, 2'b00)); tick();

        // Register 0: hardwired vs real
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_out(0, "z.a", mk(C0, 2'b00, 2'b00));
        expect_out(1, "z.a", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_out(0, "z.b", mk(C0, 2'b00, 2'b00));
        expect_out(1, "z.b", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_out(0, "z.zr1", mk(C0, 2'b00, 2'b00));
        expect_out(1, "z.zr0", mk(C0, 2'b10, 2'b10)); tick();

        // MEM_LAT=3 store: two frozen cycles, redirect held off until freeze drops
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
        expect_out(2, "st.a", mk(C0, 2'b00, 2'b00)); tick();
        idle();
        expect_out(2, "st.e", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
        expect_out(2, "st.frz1", mk(CFZ, 2'b00, 2'b00)); tick();
        expect_out(2, "st.frz2", mk(CFZ, 2'b00, 2'b00)); tick();
        expect_out(2, "st.redir", mk(CRD, 2'b00, 2'b00)); tick();
        idle();
        expect_out(2, "st.done", mk(C0, 2'b00, 2'b00)); tick();

        // MEM_LAT=3 two back-to-back loads: 2 + 2 frozen cycles
        do_reset();
        drive(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        expect_out(2, "ll.a", mk(C0, 2'b00, 2'b00)); tick();
        drive(5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        expect_out(2, "ll.b", mk(C0, 2'b00, 2'b00)); tick();
        idle();
        expect_out(2, "ll.frz1", mk(CFZ, 2'b00, 2'b00)); tick();
        expect_out(2, "ll.frz2", mk(CFZ, 2'b00, 2'b00)); tick();
        expect_out(2, "ll.gap", mk(C0, 2'b00, 2'b00)); tick();
        expect_out(2, "ll.frz3", mk(CFZ, 2'b00, 2'b00)); tick();
        expect_out(2, "ll.frz4", mk(CFZ, 2'b00, 2'b00)); tick();
        check_now(2, "ll.expired", mk(C0, 2'b00, 2'b00));
        expect_out(2, "ll.done", mk(C0, 2'b00, 2'b00)); tick();

        // MEM_LAT=4: reset asserted in the second wait cycle clears outputs at once
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
        expect_out(3, "rm.a", mk(C0, 2'b00, 2'b00)); tick();
        idle();
        expect_out(3, "rm.e", mk(C0, 2'b00, 2'b00)); tick();
        expect_out(3, "rm.frz1", mk(CFZ, 2'b00, 2'b00)); tick();
        rst = 1'b1;
        expect_out(3, "rm.async", mk(C0, 2'b00, 2'b00)); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_out(3, "rm.post", mk(C0, 2'b00, 2'b00));
            tick();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_sb.md
Name: hazard_sb

Overview:
- Parametrised successor to the pipeline hazard unit for the dual-ISA (ARM/RISC-V) 5-stage core.
- Owns its own shadow scoreboard of in-flight destination tags for E/M/W, so stages no longer export Rd/RegWrite for hazard decisions.
- Adds a multi-cycle data-memory wait (MEM_LAT), an optional hardwired-zero register, and full-pipeline freeze on top of forwarding, load-use stall and redirect flush.

Parameters:
REG_W, 5, register index width (5 for RISC-V; 4 sufficient for ARM)
MEM_LAT, 1, data-memory latency in cycles, >=1; each load/store holds M for MEM_LAT cycles
ZERO_REG, 1, 1: index 0 never creates a hazard (RISC-V x0); 0: index 0 is a real register (ARM R0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
Rs1D  in  REG_W  source 1 of instruction in D
Rs2D  in  REG_W  source 2 of instruction in D
RdD  in  REG_W  destination of instruction in D
RegWriteD  in  1  D instruction writes RdD
LoadD  in  1  D instruction is a load (result from memory)
MemAccessD  in  1  D instruction is a load or store
Rs1E  in  REG_W  source 1 of instruction in E
Rs2E  in  REG_W  source 2 of instruction in E
RedirectE  in  1  taken branch/jump resolved in E (ARM BranchTakenE / RISC-V PCSrcE)
StallF, StallD, StallE, StallM  out  1 each  hold stage register
FlushD, FlushE, FlushW  out  1 each  insert bubble into stage register
ForwardAE, ForwardBE  out  2 each  00 register file, 10 ALUResultM, 01 ResultW

Behaviour:
- State: tagE/tagM/tagW, each {rd[REG_W], wr, ld, mem}; wait counter cnt, width clog2(MEM_LAT)+1.
- rst asserted (async): all tags cleared (wr=ld=mem=0), cnt=0. Every output is combinational from state and inputs; with cleared state and idle inputs, all outputs are 0.
- match(s, tag) = tag.wr && s==tag.rd && !(ZERO_REG && s==0).
- freeze = tagM.mem && (cnt < MEM_LAT-1). Freeze is never asserted when MEM_LAT==1.
- loaduse = tagE.ld && (match(Rs1D,tagE) || match(Rs2D,tagE)).
- Output priority, highest first:
  1. freeze: StallF=StallD=StallE=StallM=1, FlushW=1; FlushD=FlushE=0. RedirectE and loaduse are ignored and re-evaluated once freeze drops (E is held, so RedirectE persists).
  2. RedirectE: FlushD=1, FlushE=1; StallF=StallD=0, even if loaduse is also true.
  3. loaduse: StallF=1, StallD=1, FlushE=1.
  4. Otherwise all stall/flush outputs are 0.
- ForwardAE: 10 if match(Rs1E,tagM) && !tagM.ld; else 01 if match(Rs1E,tagW); else 00. ForwardBE is the same using Rs2E. M has priority over W. Forwarding is evaluated during freeze, but the values are don't-care while frozen.
- Tag update per clock edge:
  - If freeze: tagE and tagM hold; tagW cleared (bubble); cnt <= cnt+1.
  - Else: tagW <= tagM; tagM <= tagE; cnt <= 0; tagE <= cleared if FlushE, else {RdD, RegWriteD, LoadD, MemAccessD}.
- Each memory access therefore freezes exactly MEM_LAT-1 cycles.
- Back-to-back memory accesses each incur the full wait, because cnt restarts at 0 when the next one enters M.
- Reset mid-freeze: cnt and tags clear immediately; no residual stall on the first cycle after rst deasserts.
- Instruction in D with RdD==0 and ZERO_REG=1: its tag carries wr but never matches.

Test Plan:
- MEM_LAT=1, ZERO_REG=1: add x5 into E; next D reads x5 -> one cycle later ForwardAE=10; the cycle after that (producer in W) ForwardAE=01. No stalls throughout.
- lw x6 then dependent add x6 in D -> exactly 1 cycle StallF=StallD=FlushE=1. Then ForwardAE=01 with the load in W.
- RedirectE=1 while loaduse is also true -> FlushD=FlushE=1, StallF=StallD=0 in the same cycle.
- MEM_LAT=3: store reaches M -> StallF/D/E/M=1 and FlushW=1 for exactly 2 cycles, then cnt returns to 0. Two consecutive loads -> 4 frozen cycles in total.
- ZERO_REG=1 vs 0: writer of register 0 followed by a reader of register 0 -> ForwardAE=00 and no stall with ZERO_REG=1; ForwardAE=10 with ZERO_REG=0.
- Assert rst during the second wait cycle with MEM_LAT=4 -> all outputs 0 asynchronously. After release with idle inputs, no stall for at least 3 cycles.
